soc_stdout_slave: RTL and testbench
===================================

# soc_stdout_slave

AXI4 slave endpoint on the SoC interconnect's stdout master port; it collects characters written by cluster cores into a byte FIFO. The FIFO drains through a valid/ready character stream toward the host-visible console logic. Reads on the same port return the current FIFO fill level so software can poll before writing. Write bursts exert backpressure when the FIFO is full, so no character is ever dropped.

## Interface
- AXI_ADDR_WIDTH, 32, address width of the slave port
- AXI_DATA_WIDTH, 64, data width; strobe width = AXI_DATA_WIDTH/8
- AXI_ID_WIDTH, 10, ID width (interconnect master-side ID width)
- AXI_USER_WIDTH, 6, user width; user outputs driven 0
- FIFO_DEPTH, 16, character FIFO entries; power of two, at least 2
- clk_i  in  1  single clock for the whole block
- rst_ni  in  1  reset, synchronous, active-low
- slave  AXI_BUS.Slave  parameterised  AXI4 port from the interconnect
- char_o  out  8  character at FIFO head
- char_valid_o  out  1  FIFO not empty
- char_ready_i  in  1  consumer accepts char_o this cycle
- fill_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On the aw handshake, latch awid and move to W_DATA.
  - W_DATA: wready = !fifo_full. Each w handshake pushes one byte. The byte is wdata[8k+:8], where k is the lowest index with wstrb[k]=1. A beat with wstrb=0 is accepted and pushes nothing. A handshake with wlast=1 moves the FSM to W_RESP. AWLEN is not used to count beats; wlast terminates.
  - W_RESP: bvalid=1, bid = latched ID, bresp=OKAY. On bready, return to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On the ar handshake, latch arid and arlen, clear the beat counter, and move to R_DATA.
  - R_DATA: rvalid=1, rresp=OKAY, rid = latched ID. rdata = fill count zero-extended, sampled combinationally each cycle. rlast=1 when beat counter == arlen. On a handshake with rlast, return to R_IDLE; otherwise increment the counter.
- Read and write FSMs run independently and concurrently.
- Address, burst type, size, cache, prot, qos, region, lock and atop are ignored. Addresses are not checked.
- FIFO pop occurs when char_valid_o && char_ready_i.
- Simultaneous push and pop: occupancy unchanged, and the push is accepted even when the FIFO is full. This means wready = !full || pop.
- Read and write pointers wrap modulo FIFO_DEPTH. The count ranges 0..FIFO_DEPTH.

## Timing
- All state is in registers updated on the rising edge of clk_i.
- With rst_ni=0 at an edge, the block resets:
  - Both FSMs go to their IDLE states.
  - Pointers and count go to 0, and FIFO contents are discarded.
  - Output values after reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bid=0, rid=0, bresp=0, rresp=0, rdata=0, char_valid_o=0, fill_o=0.
- Reset asserted mid-burst aborts the burst silently; no B or R response is issued.
- A pushed byte is visible on char_o/char_valid_o in the cycle after the w handshake (one-cycle latency).
- fill_o reflects the registered count.
- The B response is asserted the cycle after the wlast handshake.
- The first R beat is asserted the cycle after the ar handshake. Subsequent beats may complete back-to-back at one per cycle.
- aw and ar handshakes are accepted only in IDLE, so there is at most one outstanding write and one outstanding read.
- valid signals never drop without the matching ready.

## Structure
- Package soc_stdout_pkg holds:
  - write-state enum {W_IDLE, W_DATA, W_RESP}
  - read-state enum {R_IDLE, R_DATA}
  - localparams RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 (SLVERR is reserved)
- Sub-module stdout_char_fifo: a synchronous FIFO with ports DEPTH, push, pop, data_in, data_out, full, empty, count.
- The top level holds the two FSMs, the strobe priority encoder and the ID/length latches.

## Test plan
- Single-beat write: awid=0x05, wdata=0x41 (byte 'A'), wstrb=0x01, wlast=1.
  - Expected: bvalid with bid=0x05, bresp=0; char_o=0x41 one cycle later; fill_o=1.
- Strobe select: wstrb=0x0C, wdata=0x..44_33_0000.
  - Expected: byte 0x33 is pushed. A wstrb=0 beat pushes nothing, and a B response is still returned.
- Full backpressure: char_ready_i=0, 20-beat burst with FIFO_DEPTH=16.
  - Expected: wready deasserts after 16 pushes.
  - Then pulse char_ready_i: exactly one beat is accepted per pop; all 20 characters arrive in order; exactly one B response.
- Burst read: arlen=3, arid=0x3FF, with fill=7.
  - Expected: 4 R beats with rdata=7, rid=0x3FF, rlast only on the 4th.
  - A concurrent write during the burst proceeds unblocked.
- Push/pop at full: fill=16, char_ready_i=1, and a w beat in the same cycle.
  - Expected: the beat is accepted and fill stays 16.
- Reset mid-burst: rst_ni low for one cycle during W_DATA.
  - Expected: all outputs are at their reset values the next cycle, no bvalid is issued, and fill_o=0.

Source files
------------

// File: rtl/soc_stdout_pkg.sv
// Shared types and constants for the stdout AXI slave.
package soc_stdout_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  // Reserved; this slave never reports errors.
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/stdout_char_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module stdout_char_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               data_in_i,
  output logic [7:0]               data_out_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign data_out_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Storage array, not reset: contents behind the pointers are meaningless after reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_in_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/soc_stdout_slave.sv
// AXI4 slave collecting stdout characters into a FIFO; reads return the fill level.
module soc_stdout_slave
  import soc_stdout_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // AW channel
  input  logic [AXI_ID_WIDTH-1:0]       slave_aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     slave_aw_addr_i,
  input  logic [7:0]                    slave_aw_len_i,
  input  logic [2:0]                    slave_aw_size_i,
  input  logic [1:0]                    slave_aw_burst_i,
  input  logic                          slave_aw_lock_i,
  input  logic [3:0]                    slave_aw_cache_i,
  input  logic [2:0]                    slave_aw_prot_i,
  input  logic [3:0]                    slave_aw_qos_i,
  input  logic [3:0]                    slave_aw_region_i,
  input  logic [5:0]                    slave_aw_atop_i,
  input  logic [AXI_USER_WIDTH-1:0]     slave_aw_user_i,
  input  logic                          slave_aw_valid_i,
  output logic                          slave_aw_ready_o,
  // W channel
  input  logic [AXI_DATA_WIDTH-1:0]     slave_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   slave_w_strb_i,
  input  logic                          slave_w_last_i,
  input  logic [AXI_USER_WIDTH-1:0]     slave_w_user_i,
  input  logic                          slave_w_valid_i,
  output logic                          slave_w_ready_o,
  // B channel
  output logic [AXI_ID_WIDTH-1:0]       slave_b_id_o,
  output logic [1:0]                    slave_b_resp_o,
  output logic [AXI_USER_WIDTH-1:0]     slave_b_user_o,
  output logic                          slave_b_valid_o,
  input  logic                          slave_b_ready_i,
  // AR channel
  input  logic [AXI_ID_WIDTH-1:0]       slave_ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     slave_ar_addr_i,
  input  logic [7:0]                    slave_ar_len_i,
  input  logic [2:0]                    slave_ar_size_i,
  input  logic [1:0]                    slave_ar_burst_i,
  input  logic                          slave_ar_lock_i,
  input  logic [3:0]                    slave_ar_cache_i,
  input  logic [2:0]                    slave_ar_prot_i,
  input  logic [3:0]                    slave_ar_qos_i,
  input  logic [3:0]                    slave_ar_region_i,
  input  logic [AXI_USER_WIDTH-1:0]     slave_ar_user_i,
  input  logic                          slave_ar_valid_i,
  output logic                          slave_ar_ready_o,
  // R channel
  output logic [AXI_ID_WIDTH-1:0]       slave_r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]     slave_r_data_o,
  output logic [1:0]                    slave_r_resp_o,
  output logic                          slave_r_last_o,
  output logic [AXI_USER_WIDTH-1:0]     slave_r_user_o,
  output logic                          slave_r_valid_o,
  input  logic                          slave_r_ready_i,
  // Character stream
  output logic [7:0]                    char_o,
  output logic                          char_valid_o,
  input  logic                          char_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o
);

  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;
  localparam int unsigned FillW = $clog2(FIFO_DEPTH) + 1;

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0] aw_id_q, ar_id_q;
  logic [7:0]              ar_len_q, beat_q;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       push_byte;
  logic [FillW-1:0] fill;

  // Address and attribute fields carry no meaning for a single-register console port.
  logic unused_inputs;
  assign unused_inputs = ^{slave_aw_addr_i, slave_aw_len_i, slave_aw_size_i, slave_aw_burst_i,
                           slave_aw_lock_i, slave_aw_cache_i, slave_aw_prot_i, slave_aw_qos_i,
                           slave_aw_region_i, slave_aw_atop_i, slave_aw_user_i, slave_w_user_i,
                           slave_ar_addr_i, slave_ar_size_i, slave_ar_burst_i, slave_ar_lock_i,
                           slave_ar_cache_i, slave_ar_prot_i, slave_ar_qos_i, slave_ar_region_i,
                           slave_ar_user_i};

  assign fifo_pop     = !fifo_empty && char_ready_i;
  assign char_valid_o = !fifo_empty;
  assign fill_o       = fill;

  // Priority encoder: the lowest enabled strobe lane selects the character byte.
  always_comb begin
    push_byte = '0;
    for (int k = StrbW - 1; k >= 0; k--) begin
      if (slave_w_strb_i[k]) push_byte = slave_w_data_i[8*k +: 8];
    end
  end

  // Write FSM next state and handshake outputs.
  always_comb begin
    w_state_d        = w_state_q;
    slave_aw_ready_o = 1'b0;
    slave_w_ready_o  = 1'b0;
    slave_b_valid_o  = 1'b0;
    fifo_push        = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        slave_aw_ready_o = 1'b1;
        if (slave_aw_valid_i) w_state_d = W_DATA;
      end
      W_DATA: begin
        // A same-cycle pop frees a slot, so a full FIFO can still take a beat.
        slave_w_ready_o = !fifo_full || fifo_pop;
        if (slave_w_valid_i && slave_w_ready_o) begin
          fifo_push = |slave_w_strb_i;
          if (slave_w_last_i) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        slave_b_valid_o = 1'b1;
        if (slave_b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign slave_b_id_o   = aw_id_q;
  assign slave_b_resp_o = RESP_OKAY;
  assign slave_b_user_o = '0;

  // Write FSM state and AW ID latch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      aw_id_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (w_state_q == W_IDLE && slave_aw_valid_i) aw_id_q <= slave_aw_id_i;
    end
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    r_state_d        = r_state_q;
    slave_ar_ready_o = 1'b0;
    slave_r_valid_o  = 1'b0;
    slave_r_last_o   = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        slave_ar_ready_o = 1'b1;
        if (slave_ar_valid_i) r_state_d = R_DATA;
      end
      R_DATA: begin
        slave_r_valid_o = 1'b1;
        slave_r_last_o  = (beat_q == ar_len_q);
        if (slave_r_ready_i && slave_r_last_o) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign slave_r_id_o   = ar_id_q;
  assign slave_r_data_o = {{(AXI_DATA_WIDTH - FillW){1'b0}}, fill};
  assign slave_r_resp_o = RESP_OKAY;
  assign slave_r_user_o = '0;

  // Read FSM state, AR ID/length latches and beat counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      ar_id_q   <= '0;
      ar_len_q  <= '0;
      beat_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (r_state_q == R_IDLE && slave_ar_valid_i) begin
        ar_id_q  <= slave_ar_id_i;
        ar_len_q <= slave_ar_len_i;
        beat_q   <= '0;
      end else if (r_state_q == R_DATA && slave_r_ready_i && !slave_r_last_o) begin
        beat_q <= beat_q + 8'd1;
      end
    end
  end

  stdout_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (fifo_push),
    .pop_i      (fifo_pop),
    .data_in_i  (push_byte),
    .data_out_o (char_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fill)
  );

endmodule

// File: tb/tb_soc_stdout_slave.sv
// Directed bench for soc_stdout_slave with a character scoreboard.
module tb_soc_stdout_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  aw_id = '0, ar_id = '0, b_id, r_id;
  logic [7:0]  ar_len = '0;
  logic        aw_valid = 1'b0, aw_ready, ar_valid = 1'b0, ar_ready;
  logic [63:0] w_data = '0, r_data;
  logic [7:0]  w_strb = '0;
  logic        w_last = 1'b0, w_valid = 1'b0, w_ready;
  logic [1:0]  b_resp, r_resp;
  logic [5:0]  b_user, r_user;
  logic        b_valid, b_ready = 1'b0, r_valid, r_ready = 1'b0, r_last;
  logic [7:0]  char_o;
  logic        char_valid, char_ready = 1'b0;
  logic [4:0]  fill;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  soc_stdout_slave u_dut (
    .clk_i (clk), .rst_ni (rst_n),
    .slave_aw_id_i (aw_id), .slave_aw_addr_i (32'h1A10_0000), .slave_aw_len_i (8'd0),
    .slave_aw_size_i (3'd3), .slave_aw_burst_i (2'd1), .slave_aw_lock_i (1'b0),
    .slave_aw_cache_i (4'd0), .slave_aw_prot_i (3'd0), .slave_aw_qos_i (4'd0),
    .slave_aw_region_i (4'd0), .slave_aw_atop_i (6'd0), .slave_aw_user_i (6'd0),
    .slave_aw_valid_i (aw_valid), .slave_aw_ready_o (aw_ready),
    .slave_w_data_i (w_data), .slave_w_strb_i (w_strb), .slave_w_last_i (w_last),
    .slave_w_user_i (6'd0), .slave_w_valid_i (w_valid), .slave_w_ready_o (w_ready),
    .slave_b_id_o (b_id), .slave_b_resp_o (b_resp), .slave_b_user_o (b_user),
    .slave_b_valid_o (b_valid), .slave_b_ready_i (b_ready),
    .slave_ar_id_i (ar_id), .slave_ar_addr_i (32'h1A10_0000), .slave_ar_len_i (ar_len),
    .slave_ar_size_i (3'd3), .slave_ar_burst_i (2'd1), .slave_ar_lock_i (1'b0),
    .slave_ar_cache_i (4'd0), .slave_ar_prot_i (3'd0), .slave_ar_qos_i (4'd0),
    .slave_ar_region_i (4'd0), .slave_ar_user_i (6'd0),
    .slave_ar_valid_i (ar_valid), .slave_ar_ready_o (ar_ready),
    .slave_r_id_o (r_id), .slave_r_data_o (r_data), .slave_r_resp_o (r_resp),
    .slave_r_last_o (r_last), .slave_r_user_o (r_user), .slave_r_valid_o (r_valid),
    .slave_r_ready_i (r_ready),
    .char_o (char_o), .char_valid_o (char_valid), .char_ready_i (char_ready), .fill_o (fill)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every accepted character must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && char_valid && char_ready) begin
      check("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("char_order", char_o, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_idle(input string tag);
    check({tag, "_awready"}, aw_ready, 1'b1);
    check({tag, "_arready"}, ar_ready, 1'b1);
    check({tag, "_wready"}, w_ready, 1'b0);
    check({tag, "_bvalid"}, b_valid, 1'b0);
    check({tag, "_rvalid"}, r_valid, 1'b0);
    check({tag, "_rlast"}, r_last, 1'b0);
    check({tag, "_bid"}, b_id, 10'd0);
    check({tag, "_rid"}, r_id, 10'd0);
    check({tag, "_bresp"}, b_resp, 2'd0);
    check({tag, "_rresp"}, r_resp, 2'd0);
    check({tag, "_rdata"}, r_data, 64'd0);
    check({tag, "_cvalid"}, char_valid, 1'b0);
    check({tag, "_fill"}, fill, 5'd0);
  endtask

  // All stimulus tasks start and end at posedge+1.
  task automatic do_aw(input logic [9:0] id);
    int n = 0;
    aw_valid = 1'b1; aw_id = id;
    @(negedge clk);
    while (!aw_ready && n < 50) begin @(negedge clk); n++; end
    check("aw_accept", aw_ready, 1'b1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    w_valid = 1'b1; w_data = data; w_strb = strb; w_last = last;
    @(negedge clk);
    while (!w_ready && n < 100) begin @(negedge clk); n++; end
    check("w_accept", w_ready, 1'b1);
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0; w_strb = '0;
  endtask

  task automatic do_b(input logic [9:0] id);
    int n = 0;
    b_ready = 1'b1;
    @(negedge clk);
    while (!b_valid && n < 50) begin @(negedge clk); n++; end
    check("b_valid", b_valid, 1'b1);
    check("b_id", b_id, id);
    check("b_resp", b_resp, 2'd0);
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    char_ready = 1'b1;
    @(negedge clk);
    while (char_valid && n < 64) begin @(negedge clk); n++; end
    check("drain_done", char_valid, 1'b0);
    check("drain_fill", fill, 5'd0);
    @(posedge clk); #1;
    char_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;

    // Single-beat write of 'A'
    do_aw(10'h05);
    exp_q.push_back(8'h41);
    do_w(64'h41, 8'h01, 1'b1);
    @(negedge clk);
    check("single_cvalid", char_valid, 1'b1);
    check("single_char", char_o, 8'h41);
    check("single_fill", fill, 5'd1);
    check("single_bvalid", b_valid, 1'b1);
    @(posedge clk); #1;
    do_b(10'h05);

    // Strobe selection, then an empty-strobe last beat
    do_aw(10'h12);
    exp_q.push_back(8'h33);
    do_w(64'h0000_0000_4433_0000, 8'h0C, 1'b0);
    do_w(64'h0000_0000_0000_00FF, 8'h00, 1'b1);
    @(negedge clk);
    check("strobe_fill", fill, 5'd2);
    @(posedge clk); #1;
    do_b(10'h12);
    drain();

    // Full backpressure over a 20-beat burst
    do_aw(10'h11);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h60 + 8'(i));
      do_w(64'h60 + 64'(i), 8'h01, 1'b0);
    end
    for (int i = 16; i < 20; i++) begin
      w_valid = 1'b1; w_data = 64'h60 + 64'(i); w_strb = 8'h01; w_last = (i == 19);
      exp_q.push_back(8'h60 + 8'(i));
      char_ready = 1'b0;
      @(negedge clk);
      check("bp_stall", w_ready, 1'b0);
      check("bp_fill", fill, 5'd16);
      @(posedge clk); #1;
      char_ready = 1'b1;
      @(negedge clk);
      check("bp_release", w_ready, 1'b1);
      @(posedge clk); #1;
    end
    char_ready = 1'b0; w_valid = 1'b0; w_last = 1'b0; w_strb = '0;
    @(negedge clk);
    check("bp_fill_end", fill, 5'd16);
    @(posedge clk); #1;
    do_b(10'h11);
    repeat (3) begin
      @(negedge clk);
      check("bp_single_b", b_valid, 1'b0);
    end
    @(posedge clk); #1;
    drain();

    // Fill to 7, then a 4-beat read with a concurrent write
    do_aw(10'h01);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      do_w(64'h80 + 64'(i), 8'h01, i == 6);
    end
    do_b(10'h01);
    ar_valid = 1'b1; ar_id = 10'h3FF; ar_len = 8'd3;
    @(negedge clk);
    check("ar_accept", ar_ready, 1'b1);
    @(posedge clk); #1;
    ar_valid = 1'b0; r_ready = 1'b1; aw_valid = 1'b1; aw_id = 10'h21;
    @(negedge clk);
    check("rd0_valid", r_valid, 1'b1);
    check("rd0_data", r_data, 64'd7);
    check("rd0_id", r_id, 10'h3FF);
    check("rd0_last", r_last, 1'b0);
    check("rd0_resp", r_resp, 2'd0);
    check("rd_cc_awready", aw_ready, 1'b1);
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b1; w_data = 64'h5A; w_strb = 8'h01; w_last = 1'b1;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    check("rd1_data", r_data, 64'd7);
    check("rd1_last", r_last, 1'b0);
    check("rd_cc_wready", w_ready, 1'b1);
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0; w_strb = '0; b_ready = 1'b1;
    @(negedge clk);
    check("rd2_data", r_data, 64'd8);
    check("rd2_last", r_last, 1'b0);
    check("rd_cc_bvalid", b_valid, 1'b1);
    check("rd_cc_bid", b_id, 10'h21);
    @(posedge clk); #1;
    b_ready = 1'b0;
    @(negedge clk);
    check("rd3_valid", r_valid, 1'b1);
    check("rd3_data", r_data, 64'd8);
    check("rd3_last", r_last, 1'b1);
    check("rd3_id", r_id, 10'h3FF);
    @(posedge clk); #1;
    r_ready = 1'b0;
    @(negedge clk);
    check("rd_done_rvalid", r_valid, 1'b0);
    check("rd_done_arready", ar_ready, 1'b1);
    check("rd_done_bvalid", b_valid, 1'b0);
    @(posedge clk); #1;

    // Push and pop in the same cycle while full
    do_aw(10'h0A);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h90 + 8'(i));
      do_w(64'h90 + 64'(i), 8'h01, 1'b0);
    end
    @(negedge clk);
    check("pp_fill_full", fill, 5'd16);
    @(posedge clk); #1;
    w_valid = 1'b1; w_data = 64'h98; w_strb = 8'h01; w_last = 1'b1; char_ready = 1'b1;
    exp_q.push_back(8'h98);
    @(negedge clk);
    check("pp_wready", w_ready, 1'b1);
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0; w_strb = '0; char_ready = 1'b0;
    @(negedge clk);
    check("pp_fill_after", fill, 5'd16);
    check("pp_head", char_o, 8'h81);
    @(posedge clk); #1;
    do_b(10'h0A);
    drain();

    // Reset in the middle of a write burst
    do_aw(10'h07);
    do_w(64'hA0, 8'h01, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_idle("rst_mid");
    repeat (3) begin
      @(negedge clk);
      check("rst_no_b", b_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Normal traffic after the aborted burst
    do_aw(10'h03);
    exp_q.push_back(8'h42);
    do_w(64'h42, 8'h01, 1'b1);
    do_b(10'h03);
    drain();
    check("sb_empty_end", exp_q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
